// File: rtl/io_load_sequencer.sv
// Load-path sequencer: per word waits for the host interrupt, optionally routes the
// word through the decompressor, then issues a DMA write to base + word index.
module io_load_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0] FLT_BASE = ADDR_W'(16'h8000),
  parameter int unsigned       TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              cnn_img,
  input  logic              interrupt,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              decompressor_done,
  input  logic              dma_done,
  output logic              io_interface_en,
  output logic              decompressor_en,
  output logic              dma_enable,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned      TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INT,
    S_DECOMP,
    S_DMA,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              load_q;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              io_en_q, dec_en_q, dma_en_q, busy_q, done_q;

  logic              start;
  logic              last_word;
  logic              timed_out;
  logic [TMR_W-1:0]  timer_inc;
  logic [ADDR_W-1:0] slot_addr;

  assign start     = load & ~load_q;
  assign last_word = (idx_q == cnt_q - ADDR_W'(1));
  assign timer_inc = timer_q + TMR_W'(1);
  assign timed_out = (timer_inc == TMR_LIMIT);
  assign slot_addr = base_q + idx_q;

  // Next-state and session bookkeeping; abort (load low) outranks every event.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    error_d = error_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = cnn_img;
          cnt_d   = word_count;
          base_d  = cnn_img ? IMG_BASE : FLT_BASE;
          idx_d   = '0;
          error_d = 1'b0;
          state_d = (word_count == '0) ? S_DONE : S_WAIT_INT;
        end
      end
      S_WAIT_INT: begin
        if (!load) begin
          state_d = S_IDLE;
        end else if (interrupt) begin
          timer_d = '0;
          if (mode_q) begin
            state_d = S_DECOMP;
          end else begin
            state_d = S_DMA;
            addr_d  = slot_addr;
          end
        end
      end
      S_DECOMP: begin
        if (!load) begin
          state_d = S_IDLE;
        end else begin
          if (interrupt) error_d = 1'b1;
          if (decompressor_done) begin
            state_d = S_DMA;
            timer_d = '0;
            addr_d  = slot_addr;
          end else if (timed_out) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      S_DMA: begin
        if (!load) begin
          state_d = S_IDLE;
        end else begin
          if (interrupt) error_d = 1'b1;
          if (dma_done) begin
            if (last_word) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = S_WAIT_INT;
            end
          end else if (timed_out) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // load_q keeps tracking load through reset so a level held across reset is not a new start.
  always_ff @(posedge clk) begin
    load_q <= load;
  end

  // State register with outputs decoded from the next state, so they track the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      error_q  <= 1'b0;
      addr_q   <= '0;
      io_en_q  <= 1'b0;
      dec_en_q <= 1'b0;
      dma_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      error_q  <= error_d;
      addr_q   <= addr_d;
      io_en_q  <= (state_d == S_WAIT_INT);
      dec_en_q <= (state_d == S_DECOMP);
      dma_en_q <= (state_d == S_DMA);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign io_interface_en = io_en_q;
  assign decompressor_en = dec_en_q;
  assign dma_enable      = dma_en_q;
  assign dma_addr        = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule
